// File: rtl/uart_tx_feeder_pkg.sv
// Shared definitions for the UART transmit feeder: byte width, frame timing and FSM states.
package uart_tx_feeder_pkg;

  localparam int unsigned UART_BYTE_W     = 8;
  localparam int unsigned UART_FRAME_CLKS = 11;

  typedef enum logic [1:0] {
    FEED_IDLE = 2'd0,
    FEED_ACK  = 2'd1,
    FEED_DONE = 2'd2
  } feed_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO with a combinational head output and an occupancy count.
module uart_sync_fifo
  import uart_tx_feeder_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [UART_BYTE_W-1:0] wr_data,
  input  logic                   rd_en,
  output logic [UART_BYTE_W-1:0] rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W:0]        level
);

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  logic [UART_BYTE_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]      wptr;
  logic [ADDR_W-1:0]      rptr;
  logic                   push;
  logic                   pop;

  // full is taken from the registered level, so a same-cycle pop never frees a slot early
  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Queues bytes and hands them one at a time to a level-triggered UART transmitter.
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [UART_BYTE_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W:0]        level,
  output logic                   overflow,
  output logic                   ack_err,
  input  logic                   clr_err,
  output logic                   busy,
  output logic                   tx_start,
  output logic [UART_BYTE_W-1:0] tx_data,
  input  logic                   tx_finish
);

  localparam logic [3:0] TIMEOUT_CNT = 4'(ACK_TIMEOUT);

  feed_state_t            state, state_n;
  logic [3:0]             cnt, cnt_n;
  logic                   tx_start_n;
  logic [UART_BYTE_W-1:0] tx_data_n;
  logic                   ack_err_n, overflow_n;
  logic                   launch, ack_set;
  logic [UART_BYTE_W-1:0] head;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (launch),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign busy = (state != FEED_IDLE);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    tx_start_n = tx_start;
    tx_data_n  = tx_data;
    launch     = 1'b0;
    ack_set    = 1'b0;
    case (state)
      FEED_IDLE: begin
        if (tx_finish && !empty) launch = 1'b1;
      end
      FEED_ACK: begin
        if (!tx_finish) begin
          tx_start_n = 1'b0;
          state_n    = FEED_DONE;
        end else begin
          cnt_n = cnt + 4'd1;
          if (cnt_n == TIMEOUT_CNT) begin
            tx_start_n = 1'b0;
            ack_set    = 1'b1;
            state_n    = FEED_IDLE;
          end
        end
      end
      FEED_DONE: begin
        if (tx_finish) begin
          if (!empty) launch  = 1'b1;
          else        state_n = FEED_IDLE;
        end
      end
      default: begin
        tx_start_n = 1'b0;
        state_n    = FEED_IDLE;
      end
    endcase
    // IDLE and DONE share one launch path so back-to-back frames need no extra cycle
    if (launch) begin
      tx_data_n  = head;
      tx_start_n = 1'b1;
      cnt_n      = '0;
      state_n    = FEED_ACK;
    end
    ack_err_n  = ack_set || (ack_err && !clr_err);
    overflow_n = (wr_en && full) || (overflow && !clr_err);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FEED_IDLE;
      cnt      <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      ack_err  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      tx_start <= tx_start_n;
      tx_data  <= tx_data_n;
      ack_err  <= ack_err_n;
      overflow <= overflow_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench: feeder driving a behavioural UART transmitter, with a serial monitor on pin.
module tb_uart_tx_feeder;
  import uart_tx_feeder_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       clr_err = 1'b0;
  logic       tx_finish;
  logic       full, empty, overflow, ack_err, busy, tx_start;
  logic [4:0] level;
  logic [7:0] tx_data;

  logic       stub_mode = 1'b0;
  logic       stub_val  = 1'b0;
  logic       m_finish  = 1'b1;
  logic       pin       = 1'b1;
  logic [3:0] m_phase   = '0;
  logic [7:0] m_sh      = '0;

  int         cyc = 0;
  logic       mon_in = 1'b0;
  int         mon_k = 0;
  logic [7:0] mon_sh = '0;
  int         mon_start = 0;
  int         frame_err = 0;
  logic [7:0] q_byte[$];
  int         q_start[$];

  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_feeder #(
    .DEPTH       (16),
    .ADDR_W      (4),
    .ACK_TIMEOUT (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow),
    .ack_err   (ack_err),
    .clr_err   (clr_err),
    .busy      (busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_finish (tx_finish)
  );

  assign tx_finish = stub_mode ? stub_val : m_finish;

  // Transmitter: start bit, 8 data bits LSB first, finish raised with the stop bit
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_finish <= 1'b1;
      pin      <= 1'b1;
      m_phase  <= '0;
      m_sh     <= '0;
    end else if (m_phase == 4'd0) begin
      if (tx_start && !stub_mode) begin
        m_sh     <= tx_data;
        pin      <= 1'b0;
        m_finish <= 1'b0;
        m_phase  <= 4'd1;
      end
    end else if (m_phase <= 4'd8) begin
      pin     <= m_sh[0];
      m_sh    <= m_sh >> 1;
      m_phase <= m_phase + 4'd1;
    end else begin
      pin      <= 1'b1;
      m_finish <= 1'b1;
      m_phase  <= '0;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      mon_in = 1'b0;
    end else if (!mon_in) begin
      if (!pin) begin
        mon_in    = 1'b1;
        mon_k     = 0;
        mon_start = cyc;
      end
    end else if (mon_k < 8) begin
      mon_sh[mon_k] = pin;
      mon_k++;
    end else begin
      if (!pin) frame_err++;
      q_byte.push_back(mon_sh);
      q_start.push_back(mon_start);
      mon_in = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((busy || !empty || m_phase != 4'd0 || mon_in) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!tx_start && n < 8) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(tx_start), 32'd1);
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    logic [9:0] bits;
    int         n_hi;
    int         seen;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flags", {30'd0, overflow, ack_err}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 1: single byte, start asserted one clock before the start bit
    push(8'hA5);
    wait_start("t1_start_seen");
    check("t1_pin_before_start", 32'(pin), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bits[i] = pin;
    end
    check("t1_frame_bits", 32'(bits), 32'(10'b1101001010));
    wait_idle("t1_idle", 40);
    check("t1_empty", 32'(empty), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_count", 32'(q_byte.size()), 32'd1);
    if (q_byte.size() == 1) check("t1_byte", 32'(q_byte[0]), 32'hA5);
    q_byte.delete();
    q_start.delete();

    // 2: three bytes queued while the transmitter reports busy, then back-to-back
    stub_mode = 1'b1;
    stub_val  = 1'b0;
    wr_en = 1'b1;
    wr_data = 8'h01; @(negedge clk);
    wr_data = 8'h02; @(negedge clk);
    wr_data = 8'h03; @(negedge clk);
    wr_en = 1'b0;
    check("t2_level_peak", 32'(level), 32'd3);
    stub_mode = 1'b0;
    wait_idle("t2_idle", 100);
    check("t2_count", 32'(q_byte.size()), 32'd3);
    if (q_byte.size() == 3) begin
      check("t2_byte0", 32'(q_byte[0]), 32'h01);
      check("t2_byte1", 32'(q_byte[1]), 32'h02);
      check("t2_byte2", 32'(q_byte[2]), 32'h03);
      check("t2_gap01", 32'(q_start[1] - q_start[0]), 32'(UART_FRAME_CLKS));
      check("t2_gap12", 32'(q_start[2] - q_start[1]), 32'(UART_FRAME_CLKS));
    end
    q_byte.delete();
    q_start.delete();

    // 3: fill to DEPTH with no transmitter, one extra write overflows
    stub_mode = 1'b1;
    stub_val  = 1'b0;
    for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
    check("t3_full", 32'(full), 32'd1);
    check("t3_level16", 32'(level), 32'd16);
    check("t3_no_ovf_yet", 32'(overflow), 32'd0);
    push(8'hEE);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_level_hold", 32'(level), 32'd16);
    check("t3_no_start", 32'(tx_start), 32'd0);
    check("t3_not_busy", 32'(busy), 32'd0);
    stub_mode = 1'b0;
    wait_idle("t3_idle", 400);
    check("t3_count", 32'(q_byte.size()), 32'd16);
    if (q_byte.size() == 16)
      for (int i = 0; i < 16; i++) check("t3_byte", 32'(q_byte[i]), 32'(8'h40 + 8'(i)));
    clr_pulse();
    check("t3_ovf_cleared", 32'(overflow), 32'd0);
    q_byte.delete();
    q_start.delete();

    // 4: push lands on the launch cycle of the only queued byte
    stub_mode = 1'b1;
    stub_val  = 1'b0;
    push(8'h5A);
    check("t4_level1", 32'(level), 32'd1);
    stub_mode = 1'b0;
    wr_en   = 1'b1;
    wr_data = 8'hC3;
    @(negedge clk);
    wr_en = 1'b0;
    check("t4_level_kept", 32'(level), 32'd1);
    check("t4_launched", 32'(tx_start), 32'd1);
    check("t4_tx_data", 32'(tx_data), 32'h5A);
    wait_idle("t4_idle", 60);
    check("t4_count", 32'(q_byte.size()), 32'd2);
    if (q_byte.size() == 2) begin
      check("t4_first", 32'(q_byte[0]), 32'h5A);
      check("t4_second", 32'(q_byte[1]), 32'hC3);
    end
    q_byte.delete();
    q_start.delete();

    // 5: tx_finish stuck high, acknowledge never arrives
    stub_mode = 1'b1;
    stub_val  = 1'b1;
    push(8'h3C);
    wait_start("t5_start_seen");
    n_hi = 0;
    while (tx_start && n_hi < 40) begin
      n_hi++;
      @(negedge clk);
    end
    check("t5_start_width", 32'(n_hi), 32'd15);
    check("t5_ack_err", 32'(ack_err), 32'd1);
    check("t5_back_idle", 32'(busy), 32'd0);
    check("t5_byte_gone", 32'(empty), 32'd1);
    check("t5_tx_data", 32'(tx_data), 32'h3C);
    clr_pulse();
    check("t5_ack_cleared", 32'(ack_err), 32'd0);
    push(8'h3D);
    wait_start("t5_restart_seen");
    repeat (14) @(negedge clk);
    check("t5_still_start", 32'(tx_start), 32'd1);
    clr_pulse();
    check("t5_set_wins", 32'(ack_err), 32'd1);
    check("t5_start_dropped", 32'(tx_start), 32'd0);
    stub_mode = 1'b0;
    @(negedge clk);

    // 6: reset during the fourth data bit of 8'hFF with five bytes still queued
    stub_mode = 1'b1;
    stub_val  = 1'b0;
    push(8'hFF); push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
    check("t6_level6", 32'(level), 32'd6);
    q_byte.delete();
    q_start.delete();
    stub_mode = 1'b0;
    wait_start("t6_start_seen");
    repeat (5) @(negedge clk);
    check("t6_mid_bit3", 32'(pin), 32'd1);
    check("t6_level5", 32'(level), 32'd5);
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_level", 32'(level), 32'd0);
    check("t6_rst_empty", 32'(empty), 32'd1);
    check("t6_rst_start", 32'(tx_start), 32'd0);
    check("t6_rst_data", 32'(tx_data), 32'h00);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_flags", {30'd0, overflow, ack_err}, 32'd0);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_start || !pin) seen++;
    end
    check("t6_no_activity", 32'(seen), 32'd0);
    check("t6_no_frames", 32'(q_byte.size()), 32'd0);
    check("stop_bits", 32'(frame_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout required finish");
    $fatal(1);
  end

endmodule
